// File: rtl/bram_uart_dumper.sv
`default_nettype none
// ============================================================================
// Module   : bram_uart_dumper
// Purpose  : Streams the image BRAM out over a UART TX line (8N1, LSB first).
//            A start pulse in IDLE reads addresses 0..IMAGE_BYTES-1 in order
//            and serialises every byte. Each frame is preceded by a fetch
//            phase of 1+BRAM_LAT cycles. During this phase the line stays high.
// Ports    : clk       - system clock, rising edge
//            rst       - synchronous active-high reset
//            start     - begin a dump (honoured only while idle)
//            bram_addr - registered BRAM read address
//            bram_q    - BRAM read data, sampled at the end of the fetch phase
//            uart_tx   - registered serial output, idles high
//            busy      - high while a dump is in progress
//            done      - one-cycle pulse after the final stop bit
// Revision : 1.0 - initial release
// ============================================================================
module bram_uart_dumper #(
    parameter int CLKS_PER_BIT = 434,
    parameter int IMAGE_BYTES  = 38400,
    parameter int ADDR_W       = 16,
    parameter int BRAM_LAT     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [7:0]        bram_q,
    output logic              uart_tx,
    output logic              busy,
    output logic              done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int LW = (BRAM_LAT > 0) ? $clog2(BRAM_LAT + 1) : 1;

    localparam logic [CW-1:0]     C_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [LW-1:0]     C_LAT_LAST  = LW'(BRAM_LAT);
    localparam logic [ADDR_W-1:0] C_ADDR_LAST = ADDR_W'(IMAGE_BYTES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    logic [2:0]        r_state;
    logic [CW-1:0]     r_cnt;
    logic [LW-1:0]     r_lat;
    logic [2:0]        r_bitidx;
    logic [7:0]        r_shift;
    logic [ADDR_W-1:0] r_addr;
    logic              r_tx;
    logic              r_busy;
    logic              r_done;

    logic [2:0]        w_state_nxt;
    logic [CW-1:0]     w_cnt_nxt;
    logic [LW-1:0]     w_lat_nxt;
    logic [2:0]        w_bitidx_nxt;
    logic [7:0]        w_shift_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic              w_tx_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;

    logic w_bit_end;
    logic w_lat_done;
    logic w_last;

    assign w_bit_end  = (r_cnt == C_BIT_LAST);
    assign w_lat_done = (r_lat == C_LAT_LAST);
    assign w_last     = (r_addr == C_ADDR_LAST);

    // State register and all registered datapath/outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_lat    <= '0;
            r_bitidx <= '0;
            r_shift  <= '0;
            r_addr   <= '0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_lat    <= w_lat_nxt;
            r_bitidx <= w_bitidx_nxt;
            r_shift  <= w_shift_nxt;
            r_addr   <= w_addr_nxt;
            r_tx     <= w_tx_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start)      w_state_nxt = S_FETCH;
            S_FETCH: if (w_lat_done) w_state_nxt = S_START;
            S_START: if (w_bit_end)  w_state_nxt = S_DATA;
            S_DATA:  if (w_bit_end && (r_bitidx == 3'd7)) w_state_nxt = S_STOP;
            S_STOP:  if (w_bit_end)  w_state_nxt = w_last ? S_IDLE : S_FETCH;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        w_cnt_nxt    = r_cnt;
        w_lat_nxt    = r_lat;
        w_bitidx_nxt = r_bitidx;
        w_shift_nxt  = r_shift;
        w_addr_nxt   = r_addr;
        w_tx_nxt     = r_tx;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_addr_nxt   = '0;
                w_tx_nxt     = 1'b1;
                w_cnt_nxt    = '0;
                w_lat_nxt    = '0;
                w_bitidx_nxt = '0;
                if (start) begin
                    w_busy_nxt = 1'b1;
                end
            end
            S_FETCH: begin
                // Address has been stable for 1+BRAM_LAT edges when the
                // latency counter reaches BRAM_LAT, so bram_q is valid here.
                if (w_lat_done) begin
                    w_lat_nxt   = '0;
                    w_shift_nxt = bram_q;
                    w_tx_nxt    = 1'b0;
                    w_cnt_nxt   = '0;
                end else begin
                    w_lat_nxt = r_lat + 1'b1;
                end
            end
            S_START: begin
                w_cnt_nxt = w_bit_end ? '0 : r_cnt + 1'b1;
                if (w_bit_end) begin
                    w_tx_nxt     = r_shift[0];
                    w_shift_nxt  = {1'b0, r_shift[7:1]};
                    w_bitidx_nxt = '0;
                end
            end
            S_DATA: begin
                w_cnt_nxt = w_bit_end ? '0 : r_cnt + 1'b1;
                if (w_bit_end) begin
                    if (r_bitidx == 3'd7) begin
                        w_tx_nxt = 1'b1;
                    end else begin
                        w_tx_nxt     = r_shift[0];
                        w_shift_nxt  = {1'b0, r_shift[7:1]};
                        w_bitidx_nxt = r_bitidx + 1'b1;
                    end
                end
            end
            S_STOP: begin
                w_cnt_nxt = w_bit_end ? '0 : r_cnt + 1'b1;
                if (w_bit_end) begin
                    w_lat_nxt = '0;
                    if (w_last) begin
                        w_done_nxt = 1'b1;
                        w_busy_nxt = 1'b0;
                        w_addr_nxt = '0;
                    end else begin
                        w_addr_nxt = r_addr + 1'b1;
                    end
                end
            end
            default: begin
                w_tx_nxt   = 1'b1;
                w_busy_nxt = 1'b0;
                w_addr_nxt = '0;
            end
        endcase
    end

    assign bram_addr = r_addr;
    assign uart_tx   = r_tx;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_bram_uart_dumper.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_uart_dumper
// Purpose  : Scoreboard bench for bram_uart_dumper. Two DUTs (1-byte and
//            3-byte image) share one UART/done monitor through a mux.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram_uart_dumper;

    localparam int C  = 4;
    localparam int FP = 10 * C + 2;   // frame period with BRAM_LAT=1

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       use1;
    logic [7:0] a1, a3;
    logic [7:0] q1, q3;
    logic       tx1, tx3, busy1, busy3, done1, done3;
    logic       s1, s3;
    logic       tx_m, busy_m, done_m;
    logic [7:0] addr_m;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int done_seen = 0;

    int         fallq[$];
    logic [7:0] byteq[$];
    int         doneq[$];
    logic [7:0] img3 [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign s1     = start & use1;
    assign s3     = start & ~use1;
    assign tx_m   = use1 ? tx1 : tx3;
    assign busy_m = use1 ? busy1 : busy3;
    assign done_m = use1 ? done1 : done3;
    assign addr_m = use1 ? a1 : a3;

    bram_uart_dumper #(.CLKS_PER_BIT(C), .IMAGE_BYTES(1), .ADDR_W(8), .BRAM_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(s1), .bram_addr(a1), .bram_q(q1),
        .uart_tx(tx1), .busy(busy1), .done(done1)
    );

    bram_uart_dumper #(.CLKS_PER_BIT(C), .IMAGE_BYTES(3), .ADDR_W(8), .BRAM_LAT(1)) u_dut3 (
        .clk(clk), .rst(rst), .start(s3), .bram_addr(a3), .bram_q(q3),
        .uart_tx(tx3), .busy(busy3), .done(done3)
    );

    // One-cycle-latency BRAM models
    always @(posedge clk) q1 <= (a1 == 8'd0) ? 8'hA5 : 8'h00;
    always @(posedge clk)
        q3 <= (a3 == 8'd0) ? 8'h00 : (a3 == 8'd1) ? 8'hFF : (a3 == 8'd2) ? 8'h3C : 8'hEE;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, exp);
        end
    endtask

    // UART frame monitor: samples at negedges, mid-bit
    bit         m_act = 1'b0;
    int         m_cnt, m_b, m_exp;
    logic [7:0] m_byte, m_eb;
    always @(negedge clk) begin
        if (rst) begin
            m_act = 1'b0;
        end else if (!m_act) begin
            if (tx_m === 1'b0) begin
                m_act  = 1'b1;
                m_cnt  = 0;
                m_byte = '0;
                checks++;
                if (fallq.size() == 0) begin
                    errors++;
                    $display("FAIL frame_start unexpected at cycle %0d", cyc);
                end else begin
                    m_exp = fallq.pop_front();
                    if (cyc != m_exp) begin
                        errors++;
                        $display("FAIL frame_start_time got cycle %0d expected %0d", cyc, m_exp);
                    end
                end
            end
        end else begin
            m_cnt++;
            if (m_cnt >= C / 2 && ((m_cnt - C / 2) % C) == 0) begin
                m_b = (m_cnt - C / 2) / C;
                if (m_b == 0) begin
                    check("start_bit", int'(tx_m), 0);
                end else if (m_b <= 8) begin
                    m_byte[m_b-1] = tx_m;
                end else begin
                    check("stop_bit", int'(tx_m), 1);
                    m_act = 1'b0;
                    checks++;
                    if (byteq.size() == 0) begin
                        errors++;
                        $display("FAIL byte unexpected got %02h", m_byte);
                    end else begin
                        m_eb = byteq.pop_front();
                        if (m_byte !== m_eb) begin
                            errors++;
                            $display("FAIL byte got %02h expected %02h", m_byte, m_eb);
                        end
                    end
                end
            end
        end
    end

    // done monitor
    always @(negedge clk) begin
        if (!rst && done_m === 1'b1) begin
            done_seen++;
            checks++;
            if (doneq.size() == 0) begin
                errors++;
                $display("FAIL done unexpected at cycle %0d", cyc);
            end else begin
                m_exp = doneq.pop_front();
                if (cyc != m_exp) begin
                    errors++;
                    $display("FAIL done_time got cycle %0d expected %0d", cyc, m_exp);
                end
            end
        end
    end

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic at_cycle(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic go(output int e);
        @(posedge clk);
        #1;
        start = 1'b1;
        e = cyc + 1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic expect3(input int e);
        for (int k = 0; k < 3; k++) begin
            fallq.push_back(e + 2 + k * FP);
            byteq.push_back(img3[k]);
        end
        doneq.push_back(e + 3 * FP);
    endtask

    task automatic check_empty(input string name);
        check({name, "_frames_left"}, fallq.size(), 0);
        check({name, "_bytes_left"}, byteq.size(), 0);
        check({name, "_done_left"}, doneq.size(), 0);
    endtask

    int e0, e1, dummy, dcount;

    initial begin
        img3[0] = 8'h00;
        img3[1] = 8'hFF;
        img3[2] = 8'h3C;
        rst   = 1'b1;
        start = 1'b0;
        use1  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // 1. Reset and idle
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_tx", int'(tx_m), 1);
            check("idle_busy", int'(busy_m), 0);
            check("idle_done", int'(done_m), 0);
            check("idle_addr", int'(addr_m), 0);
        end

        // 2. Single-byte dump of 0xA5
        use1 = 1'b1;
        go(e0);
        fallq.push_back(e0 + 2);
        byteq.push_back(8'hA5);
        doneq.push_back(e0 + FP);
        wait_to(e0 + 1);
        check("s2_busy_start", int'(busy_m), 1);
        check("s2_tx_before_fall", int'(tx_m), 1);
        wait_to(e0 + FP - 1);
        check("s2_busy_end", int'(busy_m), 1);
        wait_to(e0 + FP);
        check("s2_busy_cleared", int'(busy_m), 0);
        wait_to(e0 + FP + 4);
        check_empty("s2");

        // 3. Multi-byte dump 00 FF 3C
        use1 = 1'b0;
        dcount = done_seen;
        go(e0);
        expect3(e0);
        wait_to(e0 + 41);
        check("s3_addr0", int'(addr_m), 0);
        wait_to(e0 + 43);
        check("s3_addr1", int'(addr_m), 1);
        wait_to(e0 + 84);
        check("s3_addr2", int'(addr_m), 2);
        wait_to(e0 + 3 * FP);
        check("s3_addr_wrap", int'(addr_m), 0);
        wait_to(e0 + 3 * FP + 4);
        check_empty("s3");
        check("s3_done_count", done_seen - dcount, 1);

        // 4. Start while busy is ignored
        dcount = done_seen;
        go(e0);
        expect3(e0);
        at_cycle(e0 + 50);
        go(dummy);
        wait_to(e0 + 3 * FP + 4);
        check_empty("s4");
        check("s4_done_count", done_seen - dcount, 1);

        // 5. Reset during byte 1 data bits
        go(e0);
        expect3(e0);
        at_cycle(e0 + 55);
        rst = 1'b1;
        fallq.delete();
        byteq.delete();
        doneq.delete();
        wait_to(e0 + 56);
        check("s5_tx", int'(tx_m), 1);
        check("s5_busy", int'(busy_m), 0);
        check("s5_addr", int'(addr_m), 0);
        at_cycle(e0 + 57);
        rst = 1'b0;
        dcount = done_seen;
        wait_to(e0 + 200);
        check("s5_no_done", done_seen - dcount, 0);
        check_empty("s5_abort");
        go(e1);
        expect3(e1);
        wait_to(e1 + 3 * FP + 4);
        check_empty("s5_replay");

        // 6. Start in the done edge is ignored; start afterwards is honoured
        dcount = done_seen;
        go(e0);
        expect3(e0);
        at_cycle(e0 + 3 * FP - 1);
        start = 1'b1;
        at_cycle(e0 + 3 * FP);
        start = 1'b0;
        wait_to(e0 + 3 * FP + 1);
        check("s6_ignored_busy", int'(busy_m), 0);
        at_cycle(e0 + 3 * FP + 1);
        start = 1'b1;
        e1 = e0 + 3 * FP + 2;
        at_cycle(e1);
        start = 1'b0;
        expect3(e1);
        wait_to(e1 + 1);
        check("s6_second_busy", int'(busy_m), 1);
        wait_to(e1 + 3 * FP + 4);
        check_empty("s6");
        check("s6_done_count", done_seen - dcount, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bram_uart_dumper.md
Name: bram_uart_dumper

Overview:
Reads the image buffer in the image BRAM sequentially from address 0 and streams every byte out over the UART TX line (8N1, LSB first). It is the read-back path for the image written by the UART receive path, and it drives the BRAM read port. A single start pulse dumps the whole image. busy and done report progress to control logic.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); must be >= 2
IMAGE_BYTES, 38400, number of bytes dumped per start; must be >= 1
ADDR_W, 16, BRAM address width; 2**ADDR_W >= IMAGE_BYTES
BRAM_LAT, 1, BRAM read latency in cycles, counted from the edge that samples bram_addr to the edge at which bram_q is valid

Ports:
clk  input  1  system clock; all logic on its rising edge
rst  input  1  synchronous reset, active-high
start  input  1  begin a dump; honoured only when busy=0
bram_addr  output  ADDR_W  BRAM read address (registered)
bram_q  input  8  BRAM read data
uart_tx  output  1  serial output; idles high
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse after the last stop bit of the image

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: bram_addr=0, uart_tx=1, busy=0, done=0. The FSM goes to IDLE and all counters clear.
- Reset mid-dump: at the next edge uart_tx=1 and the partial frame is abandoned, with no completion. No done pulse is produced.
- FSM states: IDLE, FETCH, START, DATA, STOP.
- IDLE:
  - bram_addr=0.
  - When start=1 at edge E0: busy<=1, state<=FETCH, latency counter cleared.
  - start while busy=1 is ignored. It is not queued.
- FETCH:
  - Holds bram_addr stable for 1+BRAM_LAT cycles.
  - At edge E0+1+BRAM_LAT: shift register<=bram_q, uart_tx<=0, state<=START.
- START: uart_tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles.
- STOP:
  - uart_tx=1 for CLKS_PER_BIT cycles.
  - At the final stop-bit edge, if bram_addr != IMAGE_BYTES-1: bram_addr<=bram_addr+1, state<=FETCH.
  - Otherwise: done<=1 for one cycle, busy<=0, bram_addr<=0, state<=IDLE.
- Inter-byte gap: uart_tx stays high for an extra 1+BRAM_LAT cycles between frames, which extends the stop bit. Frame period is 10*CLKS_PER_BIT+1+BRAM_LAT cycles.
- Total dump length from E0 to the done pulse: IMAGE_BYTES*(10*CLKS_PER_BIT+1+BRAM_LAT) cycles. done is asserted at edge E0+that value.
- The bit counter is modulo CLKS_PER_BIT with width $clog2(CLKS_PER_BIT). The address counter never exceeds IMAGE_BYTES-1, and there is no wrap beyond it.
- start=1 in the same cycle as the done pulse: ignored, because busy is still 1 at that edge. A new dump needs start in a later cycle.
- start=1 together with rst=1: rst wins and the dump does not begin.
- bram_q is sampled only at the FETCH capture edge. Changes to bram_q at any other time have no effect.
- uart_tx is a registered output and must be glitch-free.

Test Plan:
1. Reset and idle
   - Stimulus: hold rst for 3 cycles, then idle for 20 cycles with CLKS_PER_BIT=4, IMAGE_BYTES=3, BRAM_LAT=1.
   - Required: uart_tx=1, busy=0, done=0, bram_addr=0 throughout.
2. Single-byte dump
   - Stimulus: IMAGE_BYTES=1, BRAM model returns 0xA5 at address 0; pulse start at E0.
   - Required: uart_tx falls at E0+2. Bits sampled mid-bit are 0,1,0,1,0,0,1,0,1 (start, then LSB-first data), then stop=1. done pulses at E0+42 (1*(40+2)). busy is high over (E0, E0+42].
3. Multi-byte dump
   - Stimulus: IMAGE_BYTES=3, memory holds 0x00, 0xFF, 0x3C.
   - Required: the decoded stream is exactly 00 FF 3C. bram_addr steps 0→1→2→0. Each frame period is 42 cycles. done fires once at E0+126.
4. Start while busy
   - Stimulus: re-pulse start in the middle of byte 1.
   - Required: the byte sequence and the done timing are identical to scenario 3, with no restart.
5. Reset mid-frame
   - Stimulus: assert rst during the data bits of byte 1.
   - Required: at the next edge uart_tx=1, busy=0, bram_addr=0, and no done pulse occurs. A subsequent start replays the full image from 0x00.
6. Back-to-back dumps
   - Stimulus: pulse start 1 cycle after done.
   - Required: a second identical stream is produced.
   - Stimulus: pulse start in the done cycle.
   - Required: it is ignored.
